// File: rtl/code_compare_if.sv
// Keypad/compare bus between the code-entry stage and its driver/observer.
// Strobe inputs are sampled every rising edge; the verdict outputs are levels.
interface code_compare_if #(
  parameter int DIGIT_W = 4,
  parameter int CNT_W   = 3
);
  logic               mode;
  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               enter;
  logic               clr;
  logic [1:0]         mod3_out;
  logic [CNT_W-1:0]   digit_count;
  logic               prog_pending;
  logic               dbg_state;    // 0 = IDLE, 1 = NEWCODE

  modport master (
    output mode, key_valid, key_digit, enter, clr,
    input  mod3_out, digit_count, prog_pending, dbg_state
  );

  modport slave (
    input  mode, key_valid, key_digit, enter, clr,
    output mod3_out, digit_count, prog_pending, dbg_state
  );
endinterface

// File: rtl/code_compare.sv
// Code-entry and compare stage: buffers keypad digits, checks them against the
// stored password on an enter edge, and handles password change. Optional macro: CODE_MASTER_EN.
module code_compare #(
  parameter int                       DIGITS       = 4,
  parameter int                       DIGIT_W      = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter logic [DIGITS*DIGIT_W-1:0] MASTER_CODE  = 16'h9999
) (
  input  logic          clk,
  input  logic          rst_n,
  code_compare_if.slave bus
);
  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  typedef enum logic {IDLE = 1'b0, NEWCODE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [CODE_W-1:0] pwd_q, pwd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mod3_q, mod3_d;
  logic              enter_q;

  logic ent, full, pwd_hit, master_hit, match;

  assign ent     = bus.enter & ~enter_q;
  assign full    = (cnt_q == CNT_W'(DIGITS));
  assign pwd_hit = full && (buf_q == pwd_q);

`ifdef CODE_MASTER_EN
  assign master_hit = full && (buf_q == MASTER_CODE);
`else
  logic unused_master;
  assign unused_master = ^MASTER_CODE;
  assign master_hit    = 1'b0;
`endif

  assign match = pwd_hit | master_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      pwd_q   <= DEFAULT_CODE;
      cnt_q   <= '0;
      mod3_q  <= 2'b00;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pwd_q   <= pwd_d;
      cnt_q   <= cnt_d;
      mod3_q  <= mod3_d;
      enter_q <= bus.enter;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pwd_d   = pwd_q;
    cnt_d   = cnt_q;
    mod3_d  = mod3_q;

    if (bus.clr) begin
      state_d = IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      mod3_d  = 2'b00;
    end else if (ent) begin
      // Every enter edge consumes the entry, whatever the verdict.
      buf_d = '0;
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!bus.mode) begin
            mod3_d = match ? 2'b01 : 2'b10;
          end else if (match) begin
            mod3_d  = 2'b00;
            state_d = NEWCODE;
          end else begin
            mod3_d = 2'b10;
          end
        end
        NEWCODE: begin
          if (full) begin
            pwd_d  = buf_q;
            mod3_d = 2'b11;
          end else begin
            mod3_d = 2'b10;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if (bus.key_valid) begin
        // A full buffer drops further digits rather than wrapping.
        if (!full) begin
          buf_d = {buf_q[(DIGITS-1)*DIGIT_W-1:0], bus.key_digit};
          cnt_d = cnt_q + 1'b1;
        end
        mod3_d = 2'b00;
      end
      if (state_q == NEWCODE && !bus.mode) begin
        state_d = IDLE;
        mod3_d  = 2'b00;
      end
    end
  end

  assign bus.mod3_out     = mod3_q;
  assign bus.digit_count  = cnt_q;
  assign bus.prog_pending = (state_q == NEWCODE);
  assign bus.dbg_state    = state_q;
endmodule
